store_write_buffer: RTL and testbench

//  Committed-store write buffer downstream of the store queue. Accepts one retired store per cycle
//  (word addr + data), holds it in program order and drains it to the data-memory write port over a

---
 rtl/store_write_buffer.sv | 194 +++++++++++++++++++
 tb/tb_store_write_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_write_buffer
// Purpose  : Committed-store write buffer that sits after the store queue.
//            Accepts one retired store per cycle, keeps stores in program
//            order in a circular array and drains them to the data-memory
//            write port over a valid/ready handshake. A combinational
//            store-to-load forwarding lookup lets the load pipe see
//            buffered stores so it never reads stale memory.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_addr/in_data/in_ready        - store intake
//            mem_req_valid/addr/data, mem_req_ready   - memory drain port
//            ld_lookup_valid/addr, ld_fwd_hit/data    - load forwarding
//            wb_count, wb_empty                       - occupancy status
// Options  : WB_COALESCE_EN - when defined, a store whose youngest matching
//            buffered entry is not the head overwrites that entry's data
//            instead of allocating a new entry.
// Revision : 1.0 - initial release
// ============================================================================
module store_write_buffer #(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  // Intake from the store queue
  input  logic                        in_valid,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  // Memory write port
  output logic                        mem_req_valid,
  output logic [ADDR_W-1:0]           mem_req_addr,
  output logic [DATA_W-1:0]           mem_req_data,
  input  logic                        mem_req_ready,
  // Load forwarding lookup
  input  logic                        ld_lookup_valid,
  input  logic [ADDR_W-1:0]           ld_lookup_addr,
  output logic                        ld_fwd_hit,
  output logic [DATA_W-1:0]           ld_fwd_data,
  // Status
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_empty
);

  localparam int c_PTR_W = $clog2(WB_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  // --------------------------------------------------------------------------
  // Storage and pointers
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]   r_addr [WB_DEPTH];
  logic [DATA_W-1:0]   r_data [WB_DEPTH];
  logic [WB_DEPTH-1:0] r_vld;
  logic [c_PTR_W-1:0]  r_head;
  logic [c_PTR_W-1:0]  r_tail;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_enq;
  logic                w_deq;
  logic                w_merge;
  logic                w_alloc;

  // Forwarding search results
  logic                w_ld_found;
  logic [c_PTR_W-1:0]  w_ld_idx;
  logic [c_PTR_W-1:0]  w_ld_scan;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  // Flow control looks only at the registered count, so in_ready never
  // depends on mem_req_ready: a full buffer refuses intake even when the
  // head is leaving in the same cycle.
  assign w_full   = (r_count == c_CNT_W'(WB_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_enq    = in_valid && !w_full;
  assign w_deq    = !w_empty && mem_req_ready;
  assign w_alloc  = w_enq && !w_merge;

  // --------------------------------------------------------------------------
  // Optional store coalescing
  // --------------------------------------------------------------------------
`ifdef WB_COALESCE_EN
  logic                w_cl_found;
  logic [c_PTR_W-1:0]  w_cl_idx;
  logic [c_PTR_W-1:0]  w_cl_scan;

  // Walk from the youngest slot (tail-1) towards the oldest; the first
  // valid match is the youngest one. Only valid entries are considered, so
  // free slots reached by the walk are skipped.
  always_comb begin
    w_cl_found = 1'b0;
    w_cl_idx   = '0;
    w_cl_scan  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      w_cl_scan = r_tail - c_PTR_W'(i + 1);
      if (!w_cl_found && r_vld[w_cl_scan] && (r_addr[w_cl_scan] == in_addr)) begin
        w_cl_found = 1'b1;
        w_cl_idx   = w_cl_scan;
      end
    end
  end

  // The head is locked because it is already presented to memory; a store
  // whose youngest match is the head must allocate to preserve what memory
  // may be accepting right now.
  assign w_merge = w_enq && w_cl_found && (w_cl_idx != r_head);
`else
  assign w_merge = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // Head retirement. Slots are distinct from the tail slot whenever
      // an allocation can happen (not full), so the two updates never
      // collide on r_vld.
      if (w_deq) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + c_PTR_W'(1);
      end

      if (w_alloc) begin
        r_addr[r_tail] <= in_addr;
        r_data[r_tail] <= in_data;
        r_vld[r_tail]  <= 1'b1;
        r_tail         <= r_tail + c_PTR_W'(1);
      end
`ifdef WB_COALESCE_EN
      else if (w_merge) begin
        r_data[w_cl_idx] <= in_data;
      end
`endif

      unique case ({w_alloc, w_deq})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Memory drain port: head entry presented with zero latency
  // --------------------------------------------------------------------------
  assign mem_req_valid = !w_empty;
  assign mem_req_addr  = w_empty ? '0 : r_addr[r_head];
  assign mem_req_data  = w_empty ? '0 : r_data[r_head];

  // --------------------------------------------------------------------------
  // Store-to-load forwarding over registered entries only. A store being
  // enqueued this cycle is not yet visible; the head keeps forwarding even
  // in the cycle memory accepts it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ld_found = 1'b0;
    w_ld_idx   = '0;
    w_ld_scan  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      w_ld_scan = r_tail - c_PTR_W'(i + 1);
      if (!w_ld_found && r_vld[w_ld_scan] && (r_addr[w_ld_scan] == ld_lookup_addr)) begin
        w_ld_found = 1'b1;
        w_ld_idx   = w_ld_scan;
      end
    end
  end

  assign ld_fwd_hit  = ld_lookup_valid && w_ld_found;
  assign ld_fwd_data = ld_fwd_hit ? r_data[w_ld_idx] : '0;

  // --------------------------------------------------------------------------
  // Status
  // --------------------------------------------------------------------------
  assign in_ready = !w_full;
  assign wb_count = r_count;
  assign wb_empty = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_write_buffer
// Purpose  : Self-checking bench for store_write_buffer. Accepted stores are
//            pushed into an expected-write queue at drive time; a monitor
//            pops and compares whenever memory accepts a request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_write_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_req_ready;
  logic        ld_lookup_valid;
  logic [31:0] ld_lookup_addr;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic [2:0]  wb_count;
  logic        wb_empty;

  int total;
  int bad;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];

  store_write_buffer #(
    .WB_DEPTH (4),
    .ADDR_W   (32),
    .DATA_W   (32)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_addr         (in_addr),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_data    (mem_req_data),
    .mem_req_ready   (mem_req_ready),
    .ld_lookup_valid (ld_lookup_valid),
    .ld_lookup_addr  (ld_lookup_addr),
    .ld_fwd_hit      (ld_fwd_hit),
    .ld_fwd_data     (ld_fwd_data),
    .wb_count        (wb_count),
    .wb_empty        (wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected-write model. With coalescing, a store merges into the youngest
  // queued match unless that match is the head (queue position 0).
  task automatic sb_push(input logic [31:0] a, input logic [31:0] d);
    int  m;
    bit  merged;
    wr_t e;
    m      = -1;
    merged = 1'b0;
`ifdef WB_COALESCE_EN
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (m < 0 && sb_q[i].addr == a) m = i;
    end
    if (m > 0) begin
      sb_q[m].data = d;
      merged       = 1'b1;
    end
`endif
    if (!merged) begin
      e.addr = a;
      e.data = d;
      sb_q.push_back(e);
    end
  endtask

  // Memory-side monitor: inputs change only just after posedge, so the
  // negedge view is exactly what the next posedge will accept.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && mem_req_valid && mem_req_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("mem_unexpected", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check_eq("mem_addr", 64'(mem_req_addr), 64'(e.addr));
        check_eq("mem_data", 64'(mem_req_data), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    if (in_ready) sb_push(a, d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain_all(output int n);
    n = 0;
    mem_req_ready = 1'b1;
    while (!wb_empty && n < 50) begin
      step();
      n++;
    end
    mem_req_ready = 1'b0;
    check_eq("drain_done", 64'(wb_empty), 64'd1);
  endtask

  task automatic lookup(input string tag, input logic [31:0] a,
                        input logic exp_hit, input logic [31:0] exp_data);
    ld_lookup_valid = 1'b1;
    ld_lookup_addr  = a;
    #1;
    check_eq({tag, "_hit"},  64'(ld_fwd_hit),  64'(exp_hit));
    check_eq({tag, "_data"}, 64'(ld_fwd_data), 64'(exp_data));
    ld_lookup_valid = 1'b0;
  endtask

  initial begin
    int n;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    mem_req_ready   = 1'b0;
    ld_lookup_valid = 1'b0;
    ld_lookup_addr  = '0;

    // ---------------- reset values
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("rst_in_ready",  64'(in_ready),      64'd1);
    check_eq("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check_eq("rst_mem_addr",  64'(mem_req_addr),  64'd0);
    check_eq("rst_mem_data",  64'(mem_req_data),  64'd0);
    check_eq("rst_count",     64'(wb_count),      64'd0);
    check_eq("rst_empty",     64'(wb_empty),      64'd1);
    lookup("rst_fwd", 32'h0, 1'b0, 32'h0);

    // ---------------- fill with memory stalled
    enq(32'h40, 32'hA0);
    check_eq("first_mem_valid", 64'(mem_req_valid), 64'd1);
    enq(32'h41, 32'hA1);
    enq(32'h42, 32'hA2);
    enq(32'h43, 32'hA3);
    check_eq("fill_count",    64'(wb_count),     64'd4);
    check_eq("fill_in_ready", 64'(in_ready),     64'd0);
    check_eq("fill_head",     64'(mem_req_addr), 64'h40);
    // Upstream protocol violation while full must not be recorded
    enq(32'h99, 32'hDEAD);
    check_eq("full_count",    64'(wb_count),     64'd4);
    check_eq("full_head",     64'(mem_req_addr), 64'h40);
    check_eq("full_head_dat", 64'(mem_req_data), 64'hA0);

    // ---------------- drain in order, one per cycle
    drain_all(n);
    check_eq("drain_cycles", 64'(n), 64'd4);

    // ---------------- concurrent enq+deq at count=2, pointers wrap
    enq(32'h300, 32'h1);
    enq(32'h301, 32'h2);
    check_eq("cc_count0", 64'(wb_count), 64'd2);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enq(32'h302 + 32'(i), 32'h3 + 32'(i));
      check_eq("cc_count", 64'(wb_count), 64'd2);
    end
    drain_all(n);

    // ---------------- forwarding, youngest wins
    enq(32'h100, 32'hAAAA);
    enq(32'h100, 32'hBBBB);
    check_eq("fwd_count", 64'(wb_count), 64'd2);
    lookup("fwd_100", 32'h100, 1'b1, 32'hBBBB);
    lookup("fwd_104", 32'h104, 1'b0, 32'h0);
    ld_lookup_addr = 32'h100;
    #1;
    check_eq("fwd_novalid_hit", 64'(ld_fwd_hit), 64'd0);
    drain_all(n);

    // ---------------- same-cycle enqueue is invisible until next cycle
    in_valid = 1'b1;
    in_addr  = 32'h200;
    in_data  = 32'h55;
    if (in_ready) sb_push(32'h200, 32'h55);
    lookup("same_cyc", 32'h200, 1'b0, 32'h0);
    step();
    in_valid = 1'b0;
    lookup("next_cyc", 32'h200, 1'b1, 32'h55);
    // Head still forwards in the cycle memory accepts it
    mem_req_ready = 1'b1;
    lookup("head_acc", 32'h200, 1'b1, 32'h55);
    step();
    mem_req_ready = 1'b0;
    check_eq("after_acc_empty", 64'(wb_empty), 64'd1);
    lookup("after_acc", 32'h200, 1'b0, 32'h0);

    // ---------------- coalescing behaviour
    enq(32'h10, 32'h7);
    enq(32'h20, 32'h1);
    enq(32'h20, 32'h2);
`ifdef WB_COALESCE_EN
    check_eq("coal_count", 64'(wb_count), 64'd2);
`else
    check_eq("coal_count", 64'(wb_count), 64'd3);
`endif
    lookup("coal_fwd", 32'h20, 1'b1, 32'h2);
    enq(32'h10, 32'h9);
`ifdef WB_COALESCE_EN
    check_eq("coal_head_alloc", 64'(wb_count), 64'd3);
`else
    check_eq("coal_head_alloc", 64'(wb_count), 64'd4);
`endif
    lookup("coal_fwd10", 32'h10, 1'b1, 32'h9);
    drain_all(n);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    // ---------------- reset mid-drain with count=3
    enq(32'h500, 32'h11);
    enq(32'h501, 32'h12);
    enq(32'h502, 32'h13);
    enq(32'h503, 32'h14);
    mem_req_ready = 1'b1;
    step();
    check_eq("pre_rst_count", 64'(wb_count), 64'd3);
    rst = 1'b1;
    sb_q.delete();
    #1;
    check_eq("mid_rst_valid", 64'(mem_req_valid), 64'd0);
    check_eq("mid_rst_count", 64'(wb_count),      64'd0);
    check_eq("mid_rst_ready", 64'(in_ready),      64'd1);
    step();
    rst = 1'b0;
    step();
    check_eq("post_rst_valid", 64'(mem_req_valid), 64'd0);
    lookup("post_rst_fwd", 32'h503, 1'b0, 32'h0);
    mem_req_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
